// File: rtl/ttrng_top.sv
// ttrng_top: pseudo-random byte generator tile.
//
// Three generators step together on every enabled clock:
//   A: 16-bit Fibonacci LFSR (seed 16'hACE1)
//   B: 32-bit xorshift32 (seed 32'h2545F491)
//   C: 8-bit Galois LFSR (seed 8'h01)
// ui_in[1:0] selects which low byte drives uo_out (11 = XOR of all three).
//
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset, reseeds all generators
//   ena     - tile enable; generators step only while high
//   ui_in   - [1:0] selector, [2] seed_load, [3] hold, [7:4] unused
//   uo_out  - selected random byte
//   uio_in  - seed byte, sampled while seed_load=1
//   uio_out - tied to 8'h00
//   uio_oe  - tied to 8'h00 (bidirectional pins are inputs)
//
// Build option: define TTRNG_OUTREG_EN to register uo_out (one cycle of
// extra latency, register reset to 8'h00, not gated by ena/hold).

module ttrng_top (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [15:0] SeedA = 16'hACE1;
  localparam logic [31:0] SeedB = 32'h2545F491;
  localparam logic [7:0]  SeedC = 8'h01;

  logic [1:0]  sel;
  logic        seed_load;
  logic        hold;
  logic        unused_ui;

  assign sel       = ui_in[1:0];
  assign seed_load = ui_in[2];
  assign hold      = ui_in[3];
  assign unused_ui = ^ui_in[7:4];

  logic [15:0] a_q, a_d;
  logic [31:0] b_q, b_d, b_t1, b_t2;
  logic [7:0]  c_q, c_d;
  logic [7:0]  seed;
  logic [7:0]  sel_byte;

  // A zero seed would lock the LFSRs, so it is replaced by 8'h01.
  assign seed = (uio_in == 8'h00) ? 8'h01 : uio_in;

  always_comb begin
    a_d  = {a_q[0] ^ a_q[2] ^ a_q[3] ^ a_q[5], a_q[15:1]};
    b_t1 = b_q ^ (b_q << 13);
    b_t2 = b_t1 ^ (b_t1 >> 17);
    b_d  = b_t2 ^ (b_t2 << 5);
    c_d  = c_q[0] ? ((c_q >> 1) ^ 8'hB8) : (c_q >> 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= SeedA;
      b_q <= SeedB;
      c_q <= SeedC;
    end else if (seed_load) begin
      // Only the low bytes are reseeded; upper bits of A and B are kept.
      a_q[7:0] <= seed;
      b_q[7:0] <= seed;
      c_q      <= seed;
    end else if (ena && !hold) begin
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
    end
  end

  always_comb begin
    sel_byte = 8'h00;
    unique case (sel)
      2'b00:   sel_byte = a_q[7:0];
      2'b01:   sel_byte = b_q[7:0];
      2'b10:   sel_byte = c_q;
      default: sel_byte = a_q[7:0] ^ b_q[7:0] ^ c_q;
    endcase
  end

`ifdef TTRNG_OUTREG_EN
  logic [7:0] out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= 8'h00;
    end else begin
      out_q <= sel_byte;
    end
  end

  assign uo_out = out_q;
`else
  assign uo_out = sel_byte;
`endif

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_ttrng_top.sv
// Self-checking bench for ttrng_top (default build, combinational uo_out).
// Table of directed vectors from reset, then hand-written sequences for
// mid-run reset, long run with selector switch, hold/release and held seed_load.

module tb_ttrng_top;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [1:0] sel;
  logic       seed_load;
  logic       hold;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_pass = 0;
  int n_total = 0;

  assign ui_in = {4'h0, hold, seed_load, sel};

  always #5 clk = ~clk;

  ttrng_top dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  typedef struct {
    logic [1:0] sel;
    logic       seed_load;
    logic       hold;
    logic       ena;
    logic [7:0] uio;
    logic [7:0] exp;
  } vec_t;

  localparam int NVec = 17;
  vec_t vecs [NVec];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h, expected %02h", name, act, exp);
  endtask

  function automatic logic [7:0] c_next(input logic [7:0] x);
    return x[0] ? ((x >> 1) ^ 8'hB8) : (x >> 1);
  endfunction

  function automatic logic [31:0] b_next(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    return t ^ (t << 5);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  c_m;
  logic [31:0] b_m;

  initial begin
    // sel, seed_load, hold, ena, uio_in, expected uo_out (before the clock)
    vecs[0]  = '{2'b10, 1'b0, 1'b0, 1'b1, 8'h00, 8'h01};
    vecs[1]  = '{2'b10, 1'b0, 1'b0, 1'b1, 8'h00, 8'hB8};
    vecs[2]  = '{2'b10, 1'b0, 1'b0, 1'b1, 8'h00, 8'h5C};
    vecs[3]  = '{2'b10, 1'b0, 1'b0, 1'b1, 8'h00, 8'h2E};
    vecs[4]  = '{2'b10, 1'b0, 1'b0, 1'b1, 8'h00, 8'h17};
    vecs[5]  = '{2'b10, 1'b0, 1'b1, 1'b1, 8'h00, 8'hB3};
    vecs[6]  = '{2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 8'hB3};
    vecs[7]  = '{2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h67};  // a = 1567 after 5 steps
    vecs[8]  = '{2'b10, 1'b1, 1'b0, 1'b0, 8'h00, 8'hB3};  // zero seed -> 01, ena=0
    vecs[9]  = '{2'b10, 1'b0, 1'b0, 1'b1, 8'h00, 8'h01};
    vecs[10] = '{2'b10, 1'b0, 1'b0, 1'b1, 8'h00, 8'hB8};
    vecs[11] = '{2'b10, 1'b1, 1'b1, 1'b1, 8'h5A, 8'h5C};  // seed under hold
    vecs[12] = '{2'b11, 1'b0, 1'b1, 1'b1, 8'h00, 8'h5A};  // 5A^5A^5A
    vecs[13] = '{2'b01, 1'b0, 1'b1, 1'b1, 8'h00, 8'h5A};
    vecs[14] = '{2'b00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h5A};  // a 455A -> A2AD
    vecs[15] = '{2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h2D};
    vecs[16] = '{2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'hAD};

    rst = 1'b1; ena = 1'b0; sel = 2'b00; seed_load = 1'b0; hold = 1'b0; uio_in = 8'h00;

    // Reset values for every selector
    #1 check("rst_sel00", uo_out, 8'hE1);
    sel = 2'b01; #1 check("rst_sel01", uo_out, 8'h91);
    sel = 2'b10; #1 check("rst_sel10", uo_out, 8'h01);
    sel = 2'b11; #1 check("rst_sel11", uo_out, 8'h71);
    check("rst_uio_oe", uio_oe, 8'h00);
    check("rst_uio_out", uio_out, 8'h00);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NVec; i++) begin
      sel = vecs[i].sel; seed_load = vecs[i].seed_load; hold = vecs[i].hold;
      ena = vecs[i].ena; uio_in = vecs[i].uio;
      #1;
      check($sformatf("vec%0d", i), uo_out, vecs[i].exp);
      step();
    end

    // Asynchronous reset mid-run, then resume
    sel = 2'b10; seed_load = 1'b0; hold = 1'b0; ena = 1'b1;
    rst = 1'b1;
    #1 check("midrst_c", uo_out, 8'h01);
    sel = 2'b00; #1 check("midrst_a", uo_out, 8'hE1);
    @(negedge clk);
    rst = 1'b0; sel = 2'b10;
    step();
    check("post_rst_c", uo_out, 8'hB8);

    // 20 cycles on B, then C must have kept stepping
    c_m = 8'hB8;
    b_m = b_next(32'h2545F491);
    sel = 2'b01;
    for (int i = 0; i < 20; i++) begin
      #1;
      check($sformatf("run_b%0d", i), uo_out, b_m[7:0]);
      check("run_uio_oe", uio_oe, 8'h00);
      check("run_uio_out", uio_out, 8'h00);
      step();
      b_m = b_next(b_m);
      c_m = c_next(c_m);
    end
    sel = 2'b10;
    #1 check("switch_c", uo_out, c_m);

    // Hold for 10 cycles, then release
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("hold%0d", i), uo_out, c_m);
    end
    hold = 1'b0;
    step();
    c_m = c_next(c_m);
    check("hold_release", uo_out, c_m);

    // ena low for 10 cycles, then release
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("ena_off%0d", i), uo_out, c_m);
    end
    ena = 1'b1;
    step();
    c_m = c_next(c_m);
    check("ena_release", uo_out, c_m);

    // seed_load held 3 cycles reloads every cycle
    seed_load = 1'b1; uio_in = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("seed_hold%0d", i), uo_out, 8'h5A);
    end
    seed_load = 1'b0;
    step();
    check("seed_resume", uo_out, 8'h2D);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
